// File: rtl/clint_unit.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer, msip software interrupt,
// and optional external interrupt presenter enabled by RSD_CLINT_EXT_IRQ_EN.
module clint_unit #(
  parameter int unsigned TICK_DIVISOR = 1,
  parameter int unsigned EXT_IRQ_NUM  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrEn,
  input  logic                   rdEn,
  input  logic [2:0]             addr,
  input  logic [31:0]            wrData,
  output logic [31:0]            rdData,
  output logic                   rdValid,
  input  logic [EXT_IRQ_NUM-1:0] extIrq,
  input  logic                   extIrqAck,
  output logic                   reqTimerInterrupt,
  output logic                   reqSoftwareInterrupt,
  output logic                   reqExternalInterrupt,
  output logic [4:0]             externalInterruptCode
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned CODE_W  = 5;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [PRESC_W-1:0] presc;
  logic               msip;
  logic [31:0]        rd_mux;
  logic               tick;
  logic               wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi;

  assign wr_msip    = wrEn && (addr == 3'd0);
  assign wr_cmp_lo  = wrEn && (addr == 3'd1);
  assign wr_cmp_hi  = wrEn && (addr == 3'd2);
  assign wr_time_lo = wrEn && (addr == 3'd3);
  assign wr_time_hi = wrEn && (addr == 3'd4);
  assign tick       = (presc == PRESC_W'(TICK_DIVISOR - 1));

  // A software write to either mtime half wins over the tick and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
      presc <= '0;
    end else if (wr_time_lo || wr_time_hi) begin
      if (wr_time_lo) mtime[31:0]  <= wrData;
      if (wr_time_hi) mtime[63:32] <= wrData;
      presc <= '0;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else begin
      if (wr_msip)   msip            <= wrData[0];
      if (wr_cmp_lo) mtimecmp[31:0]  <= wrData;
      if (wr_cmp_hi) mtimecmp[63:32] <= wrData;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      3'd0:    rd_mux = {31'b0, msip};
      3'd1:    rd_mux = mtimecmp[31:0];
      3'd2:    rd_mux = mtimecmp[63:32];
      3'd3:    rd_mux = mtime[31:0];
      3'd4:    rd_mux = mtime[63:32];
      default: rd_mux = '0;
    endcase
  end

  // Read mux samples pre-write register values, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData            <= '0;
      rdValid           <= 1'b0;
      reqTimerInterrupt <= 1'b0;
    end else begin
      rdData            <= rdEn ? rd_mux : '0;
      rdValid           <= rdEn;
      reqTimerInterrupt <= (mtime >= mtimecmp);
    end
  end

  assign reqSoftwareInterrupt = msip;

`ifdef RSD_CLINT_EXT_IRQ_EN
  typedef enum logic {EXT_IDLE, EXT_PRESENT} ext_state_t;

  ext_state_t             state, state_next;
  logic [EXT_IRQ_NUM-1:0] pending, pending_next, prev_irq, rise, ack_clr;
  logic [CODE_W-1:0]      code, code_next, lowest;

  assign rise = extIrq & ~prev_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EXT_IDLE;
      pending  <= '0;
      prev_irq <= '0;
      code     <= '0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      prev_irq <= extIrq;
      code     <= code_next;
    end
  end

  // New edges are merged after the ack clear so a coincident edge keeps the line pending.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    code_next    = code;
    lowest       = '0;
    ack_clr      = '0;
    for (int i = int'(EXT_IRQ_NUM) - 1; i >= 0; i--) begin
      if (pending[i]) lowest = CODE_W'(i);
    end
    for (int i = 0; i < int'(EXT_IRQ_NUM); i++) begin
      if (CODE_W'(i) == code) ack_clr[i] = 1'b1;
    end
    case (state)
      EXT_IDLE: begin
        if (|pending) begin
          code_next  = lowest;
          state_next = EXT_PRESENT;
        end
      end
      EXT_PRESENT: begin
        if (extIrqAck) begin
          pending_next = pending & ~ack_clr;
          state_next   = EXT_IDLE;
        end
      end
      default: state_next = EXT_IDLE;
    endcase
    pending_next = pending_next | rise;
  end

  assign reqExternalInterrupt  = (state == EXT_PRESENT);
  assign externalInterruptCode = code;
`else
  logic unused_ext;
  assign unused_ext            = ^{extIrq, extIrqAck};
  assign reqExternalInterrupt  = 1'b0;
  assign externalInterruptCode = '0;
`endif

endmodule

// File: tb/tb_clint_unit.sv
// Bench for clint_unit: two instances (divisor 4 and 1) share stimulus and are
// compared each cycle against a plain-arithmetic reference model.
module tb_clint_unit;

  localparam int unsigned N_IRQ = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wrEn = 1'b0;
  logic             rdEn = 1'b0;
  logic [2:0]       addr = '0;
  logic [31:0]      wrData = '0;
  logic [N_IRQ-1:0] extIrq = '0;
  logic             extIrqAck = 1'b0;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, tirq0, tirq1, swi0, swi1, eirq0, eirq1;
  logic [4:0]  code0, code1;

  always #5 clk = ~clk;

  clint_unit #(.TICK_DIVISOR(4), .EXT_IRQ_NUM(N_IRQ)) dut_div4 (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .addr(addr), .wrData(wrData),
    .rdData(rd_data0), .rdValid(rd_valid0), .extIrq(extIrq), .extIrqAck(extIrqAck),
    .reqTimerInterrupt(tirq0), .reqSoftwareInterrupt(swi0),
    .reqExternalInterrupt(eirq0), .externalInterruptCode(code0)
  );

  clint_unit #(.TICK_DIVISOR(1), .EXT_IRQ_NUM(N_IRQ)) dut_div1 (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .addr(addr), .wrData(wrData),
    .rdData(rd_data1), .rdValid(rd_valid1), .extIrq(extIrq), .extIrqAck(extIrqAck),
    .reqTimerInterrupt(tirq1), .reqSoftwareInterrupt(swi1),
    .reqExternalInterrupt(eirq1), .externalInterruptCode(code1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_div [2] = '{4, 1};
  logic [63:0] m_time [2];
  int          m_presc [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic [N_IRQ-1:0] m_pend, m_prev;
  logic        m_present;
  int          m_code;
  logic        x_rd_valid;
  logic [31:0] x_rd_data [2];
  logic        x_tirq [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [2:0] a);
    case (a)
      3'd0:    return {31'b0, m_msip};
      3'd1:    return m_cmp[31:0];
      3'd2:    return m_cmp[63:32];
      3'd3:    return m_time[k][31:0];
      3'd4:    return m_time[k][63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lowest_set(input logic [N_IRQ-1:0] mask);
    for (int i = 0; i < int'(N_IRQ); i++) if (mask[i]) return i;
    return 0;
  endfunction

  task automatic model_update();
    logic [N_IRQ-1:0] old_pend, rising;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k] = '0; m_presc[k] = 0; x_tirq[k] = 1'b0; x_rd_data[k] = '0;
      end
      m_cmp = '1; m_msip = 1'b0; x_rd_valid = 1'b0;
      m_pend = '0; m_prev = '0; m_present = 1'b0; m_code = 0;
      return;
    end
    x_rd_valid = rdEn;
    for (int k = 0; k < 2; k++) begin
      x_tirq[k] = (m_time[k] >= m_cmp);
      if (rdEn) x_rd_data[k] = model_read(k, addr);
    end
    if (wrEn && addr == 3'd0) m_msip = wrData[0];
    if (wrEn && addr == 3'd1) m_cmp[31:0] = wrData;
    if (wrEn && addr == 3'd2) m_cmp[63:32] = wrData;
    for (int k = 0; k < 2; k++) begin
      if (wrEn && (addr == 3'd3 || addr == 3'd4)) begin
        if (addr == 3'd3) m_time[k][31:0] = wrData;
        else              m_time[k][63:32] = wrData;
        m_presc[k] = 0;
      end else if (m_presc[k] == m_div[k] - 1) begin
        m_time[k] = m_time[k] + 64'd1;
        m_presc[k] = 0;
      end else begin
        m_presc[k] = m_presc[k] + 1;
      end
    end
    // Presenter: lowest pending line is shown until acked; fresh edges always pend.
    old_pend = m_pend;
    rising   = extIrq & ~m_prev;
    m_prev   = extIrq;
    if (m_present) begin
      if (extIrqAck) begin
        m_pend[m_code] = 1'b0;
        m_present = 1'b0;
      end
    end else if (old_pend != '0) begin
      m_code = lowest_set(old_pend);
      m_present = 1'b1;
    end
    m_pend = m_pend | rising;
  endtask

  task automatic compare_all();
    logic        exp_eirq;
    logic [4:0]  exp_code;
`ifdef RSD_CLINT_EXT_IRQ_EN
    exp_eirq = m_present;
    exp_code = 5'(m_code);
`else
    exp_eirq = 1'b0;
    exp_code = 5'd0;
`endif
    check("rd_valid_d4", 64'(rd_valid0), 64'(x_rd_valid));
    check("rd_valid_d1", 64'(rd_valid1), 64'(x_rd_valid));
    if (x_rd_valid) begin
      check("rd_data_d4", 64'(rd_data0), 64'(x_rd_data[0]));
      check("rd_data_d1", 64'(rd_data1), 64'(x_rd_data[1]));
    end
    check("tirq_d4", 64'(tirq0), 64'(x_tirq[0]));
    check("tirq_d1", 64'(tirq1), 64'(x_tirq[1]));
    check("swi_d4", 64'(swi0), 64'(m_msip));
    check("swi_d1", 64'(swi1), 64'(m_msip));
    check("eirq_d4", 64'(eirq0), 64'(exp_eirq));
    check("eirq_d1", 64'(eirq1), 64'(exp_eirq));
    check("code_d4", 64'(code0), 64'(exp_code));
    check("code_d1", 64'(code1), 64'(exp_code));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wrEn = 1'b1; addr = a; wrData = d;
    step();
    wrEn = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    rdEn = 1'b1; addr = a;
    step();
    rdEn = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("reset_rd_valid", 64'(rd_valid0), 64'd0);
    check("reset_tirq", 64'(tirq1), 64'd0);
    rst = 1'b0;

    // 40 cycles at divisor 4 gives mtime 10
    repeat (40) step();
    rd(3'd3);
    check("div4_mtime_after_40", 64'(rd_data0), 64'd10);
    check("div1_mtime_after_40", 64'(rd_data1), 64'd40);
    check("div4_rd_valid", 64'(rd_valid0), 64'd1);
    step();
    check("rd_valid_one_cycle", 64'(rd_valid0), 64'd0);

    // Timer compare rises one cycle after mtime reaches 20, falls after cmp hi write
    rst = 1'b1; step(); rst = 1'b0;
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd20);
    cnt = 2;
    while (tirq1 !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    check("tirq_rise_edge", 64'(cnt), 64'd21);
    repeat (2) step();
    wr(3'd2, 32'd1);
    check("tirq_hold_on_cmp_write", 64'(tirq1), 64'd1);
    step();
    check("tirq_fall_after_cmp_hi", 64'(tirq1), 64'd0);

    // mtime wrap against mtimecmp = 5
    wr(3'd1, 32'd5);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd4, 32'hFFFF_FFFF);
    step();
    check("tirq_before_wrap", 64'(tirq1), 64'd1);
    step();
    check("tirq_after_wrap", 64'(tirq1), 64'd0);
    rd(3'd4);
    check("mtime_hi_after_wrap", 64'(rd_data1), 64'd0);
    repeat (6) step();

    // Same-address read and write returns the old value
    wrEn = 1'b1; rdEn = 1'b1; addr = 3'd1; wrData = 32'h1234_5678;
    step();
    wrEn = 1'b0; rdEn = 1'b0;
    check("rd_wr_collision", 64'(rd_data1), 64'd5);

`ifdef RSD_CLINT_EXT_IRQ_EN
    // Priority and hold of presented code
    extIrq = 4'b0101; step(); step();
    check("ext_first_code", 64'(code1), 64'd0);
    check("ext_present", 64'(eirq1), 64'd1);
    extIrq = 4'b0111; step(); step();
    check("ext_code_held", 64'(code1), 64'd0);
    extIrqAck = 1'b1; step(); extIrqAck = 1'b0;
    check("ext_idle_after_ack", 64'(eirq1), 64'd0);
    step();
    check("ext_second_code", 64'(code1), 64'd1);
    extIrqAck = 1'b1; step(); extIrqAck = 1'b0;
    step();
    check("ext_third_code", 64'(code1), 64'd2);
    extIrqAck = 1'b1; step(); extIrqAck = 1'b0;
    step();
    // Ack coincident with new edge on same line
    extIrq = 4'b1111; step(); step();
    check("ext_line3_code", 64'(code1), 64'd3);
    extIrq = 4'b0111; step();
    extIrq = 4'b1111; extIrqAck = 1'b1; step(); extIrqAck = 1'b0;
    check("ext_drop_on_ack_edge", 64'(eirq1), 64'd0);
    step();
    check("ext_represent", 64'(eirq1), 64'd1);
    check("ext_represent_code", 64'(code1), 64'd3);
    extIrqAck = 1'b1; step(); extIrqAck = 1'b0;
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      rdEn      = $urandom_range(0, 1) == 1;
      wrEn      = ($urandom_range(0, 3) == 0);
      addr      = 3'($urandom_range(0, 7));
      wrData    = $urandom;
      if ($urandom_range(0, 3) == 0) extIrq = extIrq ^ N_IRQ'(1 << $urandom_range(0, N_IRQ - 1));
      extIrqAck = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0; extIrqAck = 1'b0; extIrq = '0;
    repeat (3) step();

    // Reset during presentation with msip set
    wr(3'd0, 32'd1);
    check("msip_set", 64'(swi1), 64'd1);
`ifdef RSD_CLINT_EXT_IRQ_EN
    extIrq = 4'b0100; step(); step();
    check("present_before_reset", 64'(eirq1), 64'd1);
`endif
    rst = 1'b1; rdEn = 1'b1; addr = 3'd0;
    step();
    rst = 1'b0; rdEn = 1'b0;
    check("rst_swi", 64'(swi1), 64'd0);
    check("rst_eirq", 64'(eirq1), 64'd0);
    check("rst_code", 64'(code1), 64'd0);
    check("rst_rd_valid", 64'(rd_valid1), 64'd0);
    check("rst_rd_data", 64'(rd_data1), 64'd0);
    check("rst_tirq", 64'(tirq1), 64'd0);
    rd(3'd1);
    check("rst_cmp_lo_d1", 64'(rd_data1), 64'hFFFF_FFFF);
    check("rst_cmp_lo_d4", 64'(rd_data0), 64'hFFFF_FFFF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clint_unit.md
CLINT_UNIT -- requirements
Module: clint_unit

Interface
REQ-001 SHALL have parameter TICK_DIVISOR, default 1, meaning clk cycles per mtime increment (1..65535).
REQ-002 SHALL have parameter EXT_IRQ_NUM, default 4, meaning number of external interrupt lines (1..31).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wrEn  input  1  register write strobe.
REQ-006 SHALL have port rdEn  input  1  register read strobe.
REQ-007 SHALL have port addr  input  3  word offset: 0 msip, 1 mtimecmp[31:0], 2 mtimecmp[63:32], 3 mtime[31:0], 4 mtime[63:32].
REQ-008 SHALL have port wrData  input  32  write data.
REQ-009 SHALL have port rdData  output  32  read data.
REQ-010 SHALL have port rdValid  output  1  rdData valid.
REQ-011 SHALL have port extIrq  input  EXT_IRQ_NUM  level external interrupt lines.
REQ-012 SHALL have port extIrqAck  input  1  CSR unit accepted presented external interrupt.
REQ-013 SHALL have port reqTimerInterrupt  output  1  drives MIP.MTIP.
REQ-014 SHALL have port reqSoftwareInterrupt  output  1  drives MIP.MSIP.
REQ-015 SHALL have port reqExternalInterrupt  output  1  drives MIP.MEIP.
REQ-016 SHALL have port externalInterruptCode  output  5  index of presented external line.

Function
REQ-017 SHALL increment 64-bit mtime by 1 when the prescaler reaches TICK_DIVISOR-1, then clear the prescaler; TICK_DIVISOR=1 increments every cycle.
REQ-018 SHALL wrap mtime from 2^64-1 to 0 without flag.
REQ-019 SHALL, on wrEn to addr 3 or 4, load that half from wrData, hold the other half, suppress that cycle's increment, and clear the prescaler.
REQ-020 SHALL, on wrEn to addr 1 or 2, load that mtimecmp half; addr 0 write sets msip=wrData[0]; addr 5..7 writes ignored.
REQ-021 SHALL register reqTimerInterrupt = (mtime >= mtimecmp, unsigned 64-bit) computed on current register values, one cycle latency.
REQ-022 SHALL drive reqSoftwareInterrupt directly from msip.
REQ-023 SHALL return rdData one cycle after rdEn with rdValid high for exactly that cycle; addr 0 returns {31'b0,msip}; addr 5..7 return 0.
REQ-024 SHALL, when wrEn and rdEn hit the same addr in one cycle, return the pre-write value.
REQ-025 SHALL set pending[i] on a rising edge of extIrq[i] (registered previous sample).
REQ-026 SHALL run external FSM IDLE/PRESENT: IDLE with any pending -> latch lowest pending index into externalInterruptCode, go PRESENT; PRESENT with extIrqAck -> clear that pending bit, go IDLE.
REQ-027 SHALL assert reqExternalInterrupt exactly in PRESENT and hold externalInterruptCode stable there even if a lower index becomes pending.
REQ-028 SHALL keep pending[i] set when a new edge on line i coincides with its ack.
REQ-029 SHALL ignore extIrqAck in IDLE.

Reset
REQ-030 SHALL on rst set mtime=0, prescaler=0, mtimecmp=all-ones, msip=0, pending=0, FSM=IDLE, previous samples=0.
REQ-031 SHALL on rst drive all outputs 0 (rdValid, rdData, all req*, externalInterruptCode) from the next cycle; in-flight read or presentation is dropped.

Configuration
REQ-032 SHALL, with RSD_CLINT_EXT_IRQ_EN defined, implement REQ-025..REQ-029.
REQ-033 SHALL, without RSD_CLINT_EXT_IRQ_EN, tie reqExternalInterrupt and externalInterruptCode to 0, ignore extIrq/extIrqAck, and remove the pending/FSM logic; timer/software paths unchanged.

Verification
REQ-034 SHALL cover: TICK_DIVISOR=4, 40 cycles after reset -> read addr 3 returns 10, rdValid one cycle after rdEn.
REQ-035 SHALL cover: write mtimecmp={0,20}, TICK_DIVISOR=1 -> reqTimerInterrupt rises the cycle after mtime reaches 20; write mtimecmp hi=1 -> falls next cycle.
REQ-036 SHALL cover: write mtime lo=32'hFFFFFFFF, hi=32'hFFFFFFFF -> mtime wraps to 0 one increment later; reqTimerInterrupt stays 1 until wrap, then 0 vs mtimecmp=5.
REQ-037 SHALL cover: extIrq[2] and extIrq[0] rise same cycle -> code 0 presented; extIrq[1] rises -> code stays 0; ack -> code 1 presented, then 2.
REQ-038 SHALL cover: ack coincident with new edge on same line -> reqExternalInterrupt drops one cycle (IDLE) then re-presents same code.
REQ-039 SHALL cover: rst asserted during PRESENT with msip=1 -> all outputs 0 next cycle, read addr 1 returns 32'hFFFFFFFF.
